// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage.
// Holds the i_BHW_CU access-type encodings, the default widths, and a helper
// that turns an access size into the byte lanes it touches.
package mem_stage_pkg;

    localparam int NB_WIDTH_DEF = 32;
    localparam int NB_ADDR_DEF  = 9;
    localparam int NB_DATA_DEF  = 8;

    // Number of byte lanes in one full word access
    localparam int N_LANES = 4;

    // i_BHW_CU[1:0] size encodings; 2'b10 is not listed and behaves as a word
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // i_BHW_CU bit that selects zero extension on loads
    localparam int UNSIGNED_BIT = 2;

    // Byte lanes (relative to the base address) covered by an access size.
    // Bit 1 of the size alone decides word-ness, so 2'b10 maps to a word.
    function automatic logic [N_LANES-1:0] lane_mask(input logic [1:0] size);
        logic [N_LANES-1:0] mask;
        mask = 4'b0001;
        if (size != SIZE_BYTE) begin
            mask[1] = 1'b1;
        end
        if (size[1]) begin
            mask[3:2] = 2'b11;
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load extender for the memory stage.
// Takes the raw little-endian 32-bit word read starting at the load address
// and the access type, and returns the sign- or zero-extended load result.
// Ports:
//   i_raw  : 4 consecutive bytes starting at the load address, byte 0 in [7:0]
//   i_bhw  : access type, [1:0] size, [2] unsigned
//   o_data : extended load result
module mem_load_ext
    import mem_stage_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF
) (
    input  logic [31:0]         i_raw,
    input  logic [2:0]          i_bhw,
    output logic [NB_WIDTH-1:0] o_data
);

    logic w_fill;

    always_comb begin
        w_fill = 1'b0;
        o_data = '0;
        case (i_bhw[1:0])
            SIZE_BYTE: begin
                w_fill      = ~i_bhw[UNSIGNED_BIT] & i_raw[7];
                o_data      = {NB_WIDTH{w_fill}};
                o_data[7:0] = i_raw[7:0];
            end
            SIZE_HALF: begin
                w_fill       = ~i_bhw[UNSIGNED_BIT] & i_raw[15];
                o_data       = {NB_WIDTH{w_fill}};
                o_data[15:0] = i_raw[15:0];
            end
            default: begin
                // Word (2'b11 and the unlisted 2'b10): passed through untouched
                o_data[31:0] = i_raw;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: byte-addressed little-endian data memory with combinational
// read and synchronous byte/half/word store.
// Ports:
//   i_clk          : clock, all state changes on rising edge
//   i_reset        : synchronous active-high reset, clears every byte
//   i_mem_addr     : byte address, only [NB_ADDR-1:0] used, wraps modulo depth
//   i_mem_data     : store data, right-aligned
//   i_mem_read_CU  : load request (read path is never gated by it)
//   i_mem_write_CU : store request
//   i_BHW_CU       : access type, [1:0] size, [2] unsigned load
//   o_read_data    : load result, valid in the same cycle as the address
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int NB_DATA  = NB_DATA_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_WIDTH-1:0] i_mem_addr,
    input  logic [NB_WIDTH-1:0] i_mem_data,
    input  logic                i_mem_read_CU,
    input  logic                i_mem_write_CU,
    input  logic [2:0]          i_BHW_CU,
    output logic [NB_WIDTH-1:0] o_read_data
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_ADDR-1:0] w_base;
    logic [NB_ADDR-1:0] w_lane_addr [N_LANES];
    logic [NB_DATA-1:0] w_lane_byte [N_LANES];
    logic [N_LANES-1:0] w_lane_en;
    logic [NB_DATA-1:0] w_mem [DEPTH];
    logic [31:0]        w_raw;

    // Upper address bits and the read strobe carry no information here
    logic w_unused;
    assign w_unused = ^{i_mem_addr[NB_WIDTH-1:NB_ADDR], i_mem_read_CU};

    assign w_base    = i_mem_addr[NB_ADDR-1:0];
    assign w_lane_en = lane_mask(i_BHW_CU[1:0]);

    // Lane k sits at base+k; the NB_ADDR-bit sum wraps around the array end
    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            w_lane_addr[k] = w_base + NB_ADDR'(k);
            w_lane_byte[k] = i_mem_data[NB_DATA*k +: NB_DATA];
        end
    end

    // One register per byte so reset can clear the whole array in one edge
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_byte
            logic [NB_DATA-1:0] r_byte;
            logic               w_hit;
            logic [NB_DATA-1:0] w_wdata;

            // Lane addresses are distinct, so at most one lane hits this byte
            always_comb begin
                w_hit   = 1'b0;
                w_wdata = '0;
                for (int k = 0; k < N_LANES; k++) begin
                    if (w_lane_en[k] && (w_lane_addr[k] == NB_ADDR'(gi))) begin
                        w_hit   = 1'b1;
                        w_wdata = w_lane_byte[k];
                    end
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_byte <= '0;
                end else if (i_mem_write_CU && w_hit) begin
                    r_byte <= w_wdata;
                end
            end

            assign w_mem[gi] = r_byte;
        end
    endgenerate

    // Read always fetches four consecutive bytes; the extender picks what it needs
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_raw[8*k +: 8] = w_mem[w_lane_addr[k]];
        end
    end

    mem_load_ext #(
        .NB_WIDTH (NB_WIDTH)
    ) u_load_ext (
        .i_raw  (w_raw),
        .i_bhw  (i_BHW_CU),
        .o_data (o_read_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_mem_read_CU;
    logic        i_mem_write_CU;
    logic [2:0]  i_BHW_CU;
    logic [31:0] o_read_data;

    int n_checks;
    int n_errors;

    mem_stage dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_mem_addr     (i_mem_addr),
        .i_mem_data     (i_mem_data),
        .i_mem_read_CU  (i_mem_read_CU),
        .i_mem_write_CU (i_mem_write_CU),
        .i_BHW_CU       (i_BHW_CU),
        .o_read_data    (o_read_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (o_read_data === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o_read_data, exp);
        end
        $display("check %-14s addr=%0d bhw=%b read=%h exp=%h", tag, i_mem_addr, i_BHW_CU, o_read_data, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] bhw);
        i_mem_addr     = addr;
        i_mem_data     = data;
        i_BHW_CU       = bhw;
        i_mem_write_CU = 1'b1;
        @(posedge i_clk);
        #1;
        i_mem_write_CU = 1'b0;
        $display("store addr=%0d data=%h bhw=%b", addr, data, bhw);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [2:0] bhw,
                      input logic [31:0] exp);
        i_mem_addr    = addr;
        i_BHW_CU      = bhw;
        i_mem_read_CU = 1'b1;
        #1;
        check(tag, exp);
        i_mem_read_CU = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        i_reset        = 1'b1;
        i_mem_addr     = '0;
        i_mem_data     = '0;
        i_mem_read_CU  = 1'b0;
        i_mem_write_CU = 1'b0;
        i_BHW_CU       = 3'b011;

        // Reset with a simultaneous word write to address 0
        @(posedge i_clk);
        #1;
        i_mem_addr     = 32'd0;
        i_mem_data     = 32'hCAFEBABE;
        i_mem_write_CU = 1'b1;
        @(posedge i_clk);
        #1;
        i_mem_write_CU = 1'b0;
        i_reset        = 1'b0;
        rd("rst_lw0",   32'd0,   3'b011, 32'h00000000);
        rd("rst_lb511", 32'd511, 3'b000, 32'h00000000);
        rd("rst_lh100", 32'd100, 3'b001, 32'h00000000);

        // Byte store and sign/zero extension
        wr(32'd4, 32'h000000FF, 3'b000);
        rd("lb4",  32'd4, 3'b000, 32'hFFFFFFFF);
        rd("lbu4", 32'd4, 3'b100, 32'h000000FF);
        rd("lw4",  32'd4, 3'b011, 32'h000000FF);

        // Half store
        wr(32'd8, 32'h0000A5A5, 3'b001);
        rd("lh8",  32'd8, 3'b001, 32'hFFFFA5A5);
        rd("lhu8", 32'd8, 3'b101, 32'h0000A5A5);
        rd("lb9",  32'd9, 3'b000, 32'hFFFFFFA5);
        rd("lw8",  32'd8, 3'b011, 32'h0000A5A5);

        // Word store
        wr(32'd12, 32'hDEADBEEF, 3'b011);
        rd("lw12",   32'd12, 3'b011, 32'hDEADBEEF);
        rd("lbu12",  32'd12, 3'b100, 32'h000000EF);
        rd("lhu14",  32'd14, 3'b101, 32'h0000DEAD);
        rd("lh14",   32'd14, 3'b001, 32'hFFFFDEAD);
        rd("lw12_10", 32'd12, 3'b010, 32'hDEADBEEF);
        rd("lwu12",  32'd12, 3'b111, 32'hDEADBEEF);

        // Wrap-around word store at the top of memory
        wr(32'd510, 32'h11223344, 3'b011);
        rd("lbu510", 32'd510, 3'b100, 32'h00000044);
        rd("lbu511", 32'd511, 3'b100, 32'h00000033);
        rd("lbu0",   32'd0,   3'b100, 32'h00000022);
        rd("lbu1",   32'd1,   3'b100, 32'h00000011);
        rd("lbu2",   32'd2,   3'b100, 32'h00000000);
        rd("lw510",  32'd510, 3'b011, 32'h11223344);
        rd("lw_hi",  32'h000003FE, 3'b011, 32'h11223344);

        // Byte store with unsigned bit set only touches one byte
        wr(32'd16, 32'hFFFFFFFF, 3'b011);
        wr(32'd16, 32'h00FF0000, 3'b100);
        rd("lw16",  32'd16, 3'b011, 32'hFFFFFF00);
        wr(32'd20, 32'h00007F80, 3'b001);
        rd("lh20",  32'd20, 3'b001, 32'h00007F80);
        rd("lb20",  32'd20, 3'b000, 32'hFFFFFF80);
        rd("lw20",  32'd20, 3'b011, 32'h00007F80);

        // Size 2'b10 stores as a word; unaligned half wraps
        wr(32'd24, 32'hA1B2C3D4, 3'b010);
        rd("lw24",   32'd24, 3'b011, 32'hA1B2C3D4);
        wr(32'd511, 32'h1234BEEF, 3'b001);
        rd("lbu511w", 32'd511, 3'b100, 32'h000000EF);
        rd("lbu0w",   32'd0,   3'b100, 32'h000000BE);
        rd("lbu1w",   32'd1,   3'b100, 32'h00000011);

        // Same-cycle store and read: old data before the edge, new after
        i_mem_addr     = 32'd12;
        i_mem_data     = 32'h01020304;
        i_BHW_CU       = 3'b011;
        i_mem_read_CU  = 1'b1;
        i_mem_write_CU = 1'b1;
        #1;
        check("rw_old", 32'hDEADBEEF);
        @(posedge i_clk);
        #1;
        i_mem_write_CU = 1'b0;
        check("rw_new", 32'h01020304);
        i_mem_read_CU = 1'b0;

        // Reset in the middle of a write sequence
        wr(32'd28, 32'h55667788, 3'b011);
        i_mem_addr     = 32'd32;
        i_mem_data     = 32'h99999999;
        i_BHW_CU       = 3'b011;
        i_mem_write_CU = 1'b1;
        i_reset        = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset        = 1'b0;
        i_mem_write_CU = 1'b0;
        rd("clr_lw32",  32'd32,  3'b011, 32'h00000000);
        rd("clr_lw28",  32'd28,  3'b011, 32'h00000000);
        rd("clr_lw12",  32'd12,  3'b011, 32'h00000000);
        rd("clr_lw510", 32'd510, 3'b011, 32'h00000000);
        rd("clr_lb4",   32'd4,   3'b000, 32'h00000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter NB_WIDTH, default 32: data and address word width in bits.
REQ-002 Parameter NB_ADDR, default 9: memory index width; capacity is 2^NB_ADDR bytes (512).
REQ-003 Parameter NB_DATA, default 8: width of one storage location (byte).
REQ-004 Port i_clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-005 Port i_reset, input, 1: reset, synchronous and active-high.
REQ-006 Port i_mem_addr, input, NB_WIDTH: byte address; only bits [NB_ADDR-1:0] are used.
REQ-007 Port i_mem_data, input, NB_WIDTH: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 Port i_mem_read_CU, input, 1: load request from control unit.
REQ-009 Port i_mem_write_CU, input, 1: store request from control unit.
REQ-010 Port i_BHW_CU, input, 3: access type; bits [1:0] size (00 byte, 01 half, 11 word, 10 treated as word); bit [2] 1 = unsigned load.
REQ-011 Port o_read_data, output, NB_WIDTH: load result, extended to NB_WIDTH.

Function
REQ-012 Storage is an array of 2^NB_ADDR bytes, little-endian: byte k of a value maps to address A+k.
REQ-013 Byte address arithmetic A+k wraps modulo 2^NB_ADDR; no alignment trap; unaligned accesses use consecutive bytes.
REQ-014 When i_mem_write_CU=1 and i_reset=0, on the rising edge: byte size writes data[7:0] to A; half writes data[15:0] to A..A+1; word writes data[31:0] to A..A+3; other bytes are unchanged.
REQ-015 i_BHW_CU[2] does not affect stores.
REQ-016 Reads are combinational from i_mem_addr and i_BHW_CU, with zero latency; o_read_data is valid in the same cycle the address is applied.
REQ-017 o_read_data is not gated by i_mem_read_CU; it always reflects the current address and type. i_mem_read_CU is accepted for pipeline compatibility only.
REQ-018 Byte load: bit[2]=0 sign-extends bit 7; bit[2]=1 zero-extends.
REQ-019 Half load: bit[2]=0 sign-extends bit 15; bit[2]=1 zero-extends.
REQ-020 Word load returns all 4 bytes unmodified, regardless of bit[2].
REQ-021 Store and read to the same address in one cycle: o_read_data shows old contents until the edge, then new contents.
REQ-022 Simultaneous i_mem_read_CU and i_mem_write_CU is legal; the store proceeds per REQ-014 and the read per REQ-021.

Reset
REQ-023 When i_reset=1 at a rising edge, every memory byte becomes 0x00; reset has priority over a simultaneous write.
REQ-024 After reset, o_read_data = 0x00000000 for every address and type until a write occurs.
REQ-025 Asserting reset during a sequence of writes discards the write in that cycle; prior contents are cleared.

Structure
REQ-026 A shared package holds the i_BHW_CU encodings (SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b11, UNSIGNED bit index 2) and the default widths.
REQ-027 One sub-module, mem_load_ext, is natural: a combinational extender that takes the raw 32-bit little-endian read word and i_BHW_CU and produces o_read_data.
REQ-028 The byte array, write-enable/byte-lane decode, and reset clear live in mem_stage.

Verification
REQ-029 Reset, then read addr 0 as a word -> 0x00000000; a write asserted together with reset leaves the target at 0.
REQ-030 SB 0x000000FF at addr 4; LB addr 4 -> 0xFFFFFFFF; LBU addr 4 -> 0x000000FF; bytes 5..7 remain 0.
REQ-031 SH 0x0000A5A5 at addr 8; LH -> 0xFFFFA5A5; LHU -> 0x0000A5A5; LB addr 9 -> 0xFFFFFFA5.
REQ-032 SW 0xDEADBEEF at addr 12; LW -> 0xDEADBEEF; LBU addr 12 -> 0x000000EF; LHU addr 14 -> 0x0000DEAD.
REQ-033 SW 0x11223344 at addr 510 -> bytes 510=0x44, 511=0x33, 0=0x22, 1=0x11; LW addr 510 -> 0x11223344 (wrap-around).
REQ-034 SB 0x00FF0000 at addr 16 (BHW 100) -> byte 16 = 0x00; then SH 0x00007F80 at addr 20 gives LH addr 20 -> 0x00007F80, and LB addr 20 -> 0xFFFFFF80.
